// File: rtl/clause_bank_rescan_if.sv
// Bus bundle between the DPLL controller and the clause bank: load port, scan
// control/results and the combinational read-back port.
interface clause_bank_rescan_if #(
  parameter int WIDTH        = 9,
  parameter int MAX_CLAUSES  = 1024,
  parameter int MAX_LITERALS = 256,
  parameter int K            = 3,
  parameter int CW           = $clog2(MAX_CLAUSES)
);
  logic [MAX_LITERALS-1:0] literal_assigned;
  logic [MAX_LITERALS-1:0] literal_bool;
  logic                    load_valid;
  logic                    load_ready;
  logic [CW-1:0]           load_idx;
  logic [K*WIDTH-1:0]      load_lits;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [CW:0]             sat_count;
  logic                    unit_found;
  logic [CW-1:0]           unit_idx;
  logic [WIDTH-1:0]        unit_lit;
  logic                    conflict_found;
  logic [CW-1:0]           conflict_idx;
  logic [CW-1:0]           rd_idx;
  logic [K*WIDTH-1:0]      rd_lits;
  logic [K-1:0]            rd_mask;
  logic                    rd_active;
  logic                    rd_valid;

  modport master (
    output literal_assigned, literal_bool, load_valid, load_idx, load_lits, start, rd_idx,
    input  load_ready, busy, done, sat_count, unit_found, unit_idx, unit_lit,
           conflict_found, conflict_idx, rd_lits, rd_mask, rd_active, rd_valid
  );

  modport slave (
    input  literal_assigned, literal_bool, load_valid, load_idx, load_lits, start, rd_idx,
    output load_ready, busy, done, sat_count, unit_found, unit_idx, unit_lit,
           conflict_found, conflict_idx, rd_lits, rd_mask, rd_active, rd_valid
  );
endinterface

// File: rtl/clause_bank_rescan.sv
// Clause store with a banked rescan engine: LANES clauses per cycle are re-evaluated
// against a snapshot of the assignment, masks/active flags rewritten, results reported.
module clause_bank_rescan #(
  parameter int WIDTH        = 9,
  parameter int MAX_CLAUSES  = 1024,
  parameter int MAX_LITERALS = 256,
  parameter int K            = 3,
  parameter int LANES        = 8
) (
  input logic                 clk,
  input logic                 rst,
  clause_bank_rescan_if.slave bus
);
  localparam int CW = $clog2(MAX_CLAUSES);
  localparam int NB = MAX_CLAUSES / LANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW = (MAX_LITERALS > 1) ? $clog2(MAX_LITERALS) : 1;
  localparam int SW = CW + 2;
  localparam logic [CW:0] SAT_MAX = (CW+1)'(MAX_CLAUSES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q;
  logic [BW-1:0]           bank_q;
  logic                    load_ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic [CW:0]             sat_count_q;
  logic                    unit_found_q;
  logic [CW-1:0]           unit_idx_q;
  logic [WIDTH-1:0]        unit_lit_q;
  logic                    conflict_found_q;
  logic [CW-1:0]           conflict_idx_q;
  logic [MAX_LITERALS-1:0] snap_asg_q;
  logic [MAX_LITERALS-1:0] snap_val_q;

  logic [K*WIDTH-1:0]      lits_q [MAX_CLAUSES];
  logic [K-1:0]            mask_q [MAX_CLAUSES];
  logic [MAX_CLAUSES-1:0]  active_q;
  logic [MAX_CLAUSES-1:0]  valid_q;

  logic [CW-1:0]           lane_idx_s  [LANES];
  logic [K-1:0]            lane_tmp_s  [LANES];
  logic [K-1:0]            lane_mask_d [LANES];
  logic                    lane_act_d  [LANES];
  logic                    lane_sat_s  [LANES];
  logic                    lane_unit_s [LANES];
  logic                    lane_conf_s [LANES];
  logic [WIDTH-1:0]        lane_ulit_s [LANES];
  logic [WIDTH-1:0]        lit_s;
  logic [WIDTH-1:0]        mag_s;
  logic                    asg_s;

  logic                    bank_unit_s;
  logic [CW-1:0]           bank_unit_idx_s;
  logic [WIDTH-1:0]        bank_unit_lit_s;
  logic                    bank_conf_s;
  logic [CW-1:0]           bank_conf_idx_s;
  logic [SW-1:0]           sat_add_s;
  logic [SW-1:0]           sat_sum_s;
  logic [CW:0]             sat_count_d;
  logic                    load_fire_s;

  function automatic logic [WIDTH-1:0] lit_mag(input logic [WIDTH-1:0] lit);
    return lit[WIDTH-1] ? (~lit + WIDTH'(1)) : lit;
  endfunction

  // The most-negative literal has no representable magnitude and counts as unassigned.
  function automatic logic lit_in_range(input logic [WIDTH-1:0] lit);
    logic [WIDTH-1:0] mag;
    mag = lit_mag(lit);
    return (lit != '0) && !mag[WIDTH-1] && (int'(mag) < MAX_LITERALS);
  endfunction

  function automatic int popcount(input logic [K-1:0] v);
    int c;
    c = 0;
    for (int j = 0; j < K; j++) begin
      c = c + int'(v[j]);
    end
    return c;
  endfunction

  assign load_fire_s = bus.load_valid & load_ready_q;

  // Per-lane evaluation of the clauses in the current bank.
  always_comb begin
    lit_s = '0;
    mag_s = '0;
    asg_s = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx_s[l]  = CW'(int'(bank_q) * LANES + l);
      lane_sat_s[l]  = 1'b0;
      lane_tmp_s[l]  = '0;
      lane_ulit_s[l] = '0;
      for (int j = 0; j < K; j++) begin
        lit_s = lits_q[lane_idx_s[l]][j*WIDTH +: WIDTH];
        mag_s = lit_mag(lit_s);
        asg_s = lit_in_range(lit_s) & snap_asg_q[LW'(mag_s)];
        lane_sat_s[l]    = lane_sat_s[l] | (asg_s & (lit_s[WIDTH-1] ^ snap_val_q[LW'(mag_s)]));
        lane_tmp_s[l][j] = (mask_q[lane_idx_s[l]][j] | ~asg_s) & (lit_s != '0);
      end
      lane_mask_d[l] = lane_tmp_s[l] & ~{K{lane_sat_s[l]}};
      lane_act_d[l]  = (active_q[lane_idx_s[l]] | (|lane_tmp_s[l])) & ~lane_sat_s[l];
      lane_unit_s[l] = valid_q[lane_idx_s[l]] & ~lane_sat_s[l] & (popcount(lane_mask_d[l]) == 1);
      lane_conf_s[l] = valid_q[lane_idx_s[l]] & ~lane_sat_s[l] & (lane_mask_d[l] == '0);
      for (int j = 0; j < K; j++) begin
        lane_ulit_s[l] = lane_mask_d[l][j] ? lits_q[lane_idx_s[l]][j*WIDTH +: WIDTH]
                                           : lane_ulit_s[l];
      end
    end
  end

  // Bank-level reduction; walking lanes downwards lets the lowest index win.
  always_comb begin
    bank_unit_s     = 1'b0;
    bank_unit_idx_s = '0;
    bank_unit_lit_s = '0;
    bank_conf_s     = 1'b0;
    bank_conf_idx_s = '0;
    sat_add_s       = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      bank_unit_idx_s = lane_unit_s[l] ? lane_idx_s[l]  : bank_unit_idx_s;
      bank_unit_lit_s = lane_unit_s[l] ? lane_ulit_s[l] : bank_unit_lit_s;
      bank_unit_s     = bank_unit_s | lane_unit_s[l];
      bank_conf_idx_s = lane_conf_s[l] ? lane_idx_s[l]  : bank_conf_idx_s;
      bank_conf_s     = bank_conf_s | lane_conf_s[l];
      sat_add_s       = sat_add_s + SW'(lane_sat_s[l] & valid_q[lane_idx_s[l]]);
    end
    sat_sum_s = SW'(sat_count_q) + sat_add_s;
    if (sat_sum_s > SW'(MAX_CLAUSES)) begin
      sat_count_d = SAT_MAX;
    end else begin
      sat_count_d = sat_sum_s[CW:0];
    end
  end

  // Control FSM, assignment snapshot and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      bank_q           <= '0;
      load_ready_q     <= 1'b1;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      sat_count_q      <= '0;
      unit_found_q     <= 1'b0;
      unit_idx_q       <= '0;
      unit_lit_q       <= '0;
      conflict_found_q <= 1'b0;
      conflict_idx_q   <= '0;
      snap_asg_q       <= '0;
      snap_val_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q          <= ST_SCAN;
            bank_q           <= '0;
            load_ready_q     <= 1'b0;
            busy_q           <= 1'b1;
            sat_count_q      <= '0;
            unit_found_q     <= 1'b0;
            unit_idx_q       <= '0;
            unit_lit_q       <= '0;
            conflict_found_q <= 1'b0;
            conflict_idx_q   <= '0;
            snap_asg_q       <= bus.literal_assigned;
            snap_val_q       <= bus.literal_bool;
          end
        end
        ST_SCAN: begin
          sat_count_q <= sat_count_d;
          if (!unit_found_q && bank_unit_s) begin
            unit_found_q <= 1'b1;
            unit_idx_q   <= bank_unit_idx_s;
            unit_lit_q   <= bank_unit_lit_s;
          end
          if (!conflict_found_q && bank_conf_s) begin
            conflict_found_q <= 1'b1;
            conflict_idx_q   <= bank_conf_idx_s;
          end
          if (bank_q == BW'(NB - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            bank_q <= bank_q + BW'(1);
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          done_q       <= 1'b0;
          busy_q       <= 1'b0;
          load_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= ST_IDLE;
          done_q       <= 1'b0;
          busy_q       <= 1'b0;
          load_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Clause storage: loads in IDLE, scan write-back of valid slots in SCAN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_CLAUSES; i++) begin
        lits_q[i] <= '0;
        mask_q[i] <= '0;
      end
      active_q <= '0;
      valid_q  <= '0;
    end else if (load_fire_s) begin
      lits_q[bus.load_idx]   <= bus.load_lits;
      active_q[bus.load_idx] <= 1'b1;
      valid_q[bus.load_idx]  <= 1'b1;
      for (int j = 0; j < K; j++) begin
        mask_q[bus.load_idx][j] <= (bus.load_lits[j*WIDTH +: WIDTH] != '0);
      end
    end else if (state_q == ST_SCAN) begin
      for (int l = 0; l < LANES; l++) begin
        if (valid_q[lane_idx_s[l]]) begin
          mask_q[lane_idx_s[l]]   <= lane_mask_d[l];
          active_q[lane_idx_s[l]] <= lane_act_d[l];
        end
      end
    end
  end

  assign bus.load_ready     = load_ready_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.sat_count      = sat_count_q;
  assign bus.unit_found     = unit_found_q;
  assign bus.unit_idx       = unit_idx_q;
  assign bus.unit_lit       = unit_lit_q;
  assign bus.conflict_found = conflict_found_q;
  assign bus.conflict_idx   = conflict_idx_q;
  assign bus.rd_lits        = lits_q[bus.rd_idx];
  assign bus.rd_mask        = mask_q[bus.rd_idx];
  assign bus.rd_active      = active_q[bus.rd_idx];
  assign bus.rd_valid       = valid_q[bus.rd_idx];
endmodule

// File: tb/tb_clause_bank_rescan.sv
// Scoreboard bench for clause_bank_rescan: directed scenarios plus randomized
// load/assign/rescan rounds checked against an integer-level clause model.
module tb_clause_bank_rescan;
  localparam int WIDTH = 9;
  localparam int NC    = 16;
  localparam int NL    = 256;
  localparam int K     = 3;
  localparam int LANES = 4;

  typedef struct {
    int         sat;
    bit         uf;
    int         ui;
    logic [8:0] ul;
    bit         cf;
    int         ci;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clause_bank_rescan_if #(.WIDTH(WIDTH), .MAX_CLAUSES(NC), .MAX_LITERALS(NL), .K(K)) bus();

  clause_bank_rescan #(
    .WIDTH(WIDTH), .MAX_CLAUSES(NC), .MAX_LITERALS(NL), .K(K), .LANES(LANES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [NL-1:0] asg = '0;
  logic [NL-1:0] val = '0;
  assign bus.literal_assigned = asg;
  assign bus.literal_bool     = val;

  int         m_lits [NC][K];
  bit [K-1:0] m_mask [NC];
  bit         m_act  [NC];
  bit         m_val  [NC];
  exp_t       sb_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("sat_count", 64'(bus.sat_count), 64'(e.sat));
        chk("unit_found", 64'(bus.unit_found), 64'(e.uf));
        chk("unit_idx", 64'(bus.unit_idx), 64'(e.ui));
        chk("unit_lit", 64'(bus.unit_lit), 64'(e.ul));
        chk("conflict_found", 64'(bus.conflict_found), 64'(e.cf));
        chk("conflict_idx", 64'(bus.conflict_idx), 64'(e.ci));
      end
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin
      for (int j = 0; j < K; j++) m_lits[i][j] = 0;
      m_mask[i] = '0;
      m_act[i]  = 1'b0;
      m_val[i]  = 1'b0;
    end
  endfunction

  function automatic void model_load(input int idx, input int l0, input int l1, input int l2);
    m_lits[idx][0] = l0;
    m_lits[idx][1] = l1;
    m_lits[idx][2] = l2;
    for (int j = 0; j < K; j++) m_mask[idx][j] = (m_lits[idx][j] != 0);
    m_act[idx] = 1'b1;
    m_val[idx] = 1'b1;
  endfunction

  // Reference rescan: walk clauses in index order with plain integer literals.
  function automatic exp_t model_scan();
    exp_t e;
    e = '{default: 0};
    for (int i = 0; i < NC; i++) begin
      if (m_val[i]) begin
        bit sat;
        bit [K-1:0] tmp;
        sat = 1'b0;
        tmp = '0;
        for (int j = 0; j < K; j++) begin
          int lit;
          int v;
          bit a;
          lit = m_lits[i][j];
          if (lit != 0) begin
            v = (lit < 0) ? -lit : lit;
            a = (v < NL) && (asg[v] == 1'b1);
            if (a && ((lit > 0) == (val[v] == 1'b1))) sat = 1'b1;
            if (m_mask[i][j] || !a) tmp[j] = 1'b1;
          end
        end
        m_act[i]  = (m_act[i] || (tmp != '0)) && !sat;
        m_mask[i] = sat ? '0 : tmp;
        if (sat) begin
          e.sat++;
        end else if ($countones(m_mask[i]) == 1 && !e.uf) begin
          e.uf = 1'b1;
          e.ui = i;
          for (int j = 0; j < K; j++) if (m_mask[i][j]) e.ul = 9'(m_lits[i][j]);
        end else if (m_mask[i] == '0 && !e.cf) begin
          e.cf = 1'b1;
          e.ci = i;
        end
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input int idx, input int l0, input int l1, input int l2);
    bus.load_valid = 1'b1;
    bus.load_idx   = 4'(idx);
    bus.load_lits  = {9'(l2), 9'(l1), 9'(l0)};
  endtask

  task automatic do_load(input int idx, input int l0, input int l1, input int l2);
    drive_load(idx, l0, l1, l2);
    model_load(idx, l0, l1, l2);
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy === 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("scan_terminates", 64'(bus.busy), 64'(0));
    chk("load_ready_idle", 64'(bus.load_ready), 64'(1));
  endtask

  task automatic run_scan(input bit with_load, input int idx, input int l0, input int l1, input int l2);
    exp_t e;
    if (with_load) begin
      drive_load(idx, l0, l1, l2);
      model_load(idx, l0, l1, l2);
    end
    e = model_scan();
    e.cyc = cyc + 5;
    sb_q.push_back(e);
    bus.start = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'(1));
    wait_idle();
  endtask

  task automatic check_store();
    logic [K*WIDTH-1:0] el;
    for (int i = 0; i < NC; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      for (int j = 0; j < K; j++) el[j*WIDTH +: WIDTH] = 9'(m_lits[i][j]);
      chk($sformatf("rd_valid[%0d]", i), 64'(bus.rd_valid), 64'(m_val[i]));
      chk($sformatf("rd_active[%0d]", i), 64'(bus.rd_active), 64'(m_act[i]));
      chk($sformatf("rd_mask[%0d]", i), 64'(bus.rd_mask), 64'(m_mask[i]));
      chk($sformatf("rd_lits[%0d]", i), 64'(bus.rd_lits), 64'(el));
    end
  endtask

  task automatic check_reset_outs();
    chk("rst_load_ready", 64'(bus.load_ready), 64'(1));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_sat_count", 64'(bus.sat_count), 64'(0));
    chk("rst_unit_found", 64'(bus.unit_found), 64'(0));
    chk("rst_unit_idx", 64'(bus.unit_idx), 64'(0));
    chk("rst_unit_lit", 64'(bus.unit_lit), 64'(0));
    chk("rst_conflict_found", 64'(bus.conflict_found), 64'(0));
    chk("rst_conflict_idx", 64'(bus.conflict_idx), 64'(0));
  endtask

  function automatic int rand_lit();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return -256;
    return ($urandom_range(0, 1) == 1 ? -1 : 1) * int'($urandom_range(1, 12));
  endfunction

  initial begin
    int prev;
    bus.load_valid = 1'b0;
    bus.load_idx   = '0;
    bus.load_lits  = '0;
    bus.start      = 1'b0;
    bus.rd_idx     = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_reset_outs();
    check_store();

    // Load and satisfy, then backtrack regrowth
    do_load(5, 3, -7, 0);
    asg[3] = 1'b1; val[3] = 1'b1;
    run_scan(1'b0, 0, 0, 0, 0);
    check_store();
    asg[3] = 1'b0;
    run_scan(1'b0, 0, 0, 0, 0);
    check_store();

    // Satisfy slot 2, then falsify every literal to make it a conflict, then a unit
    do_load(2, 1, 2, 4);
    do_load(9, -1, -2, 0);
    asg[1] = 1'b1; val[1] = 1'b1;
    run_scan(1'b0, 0, 0, 0, 0);
    asg[1] = 1'b1; val[1] = 1'b0;
    asg[2] = 1'b1; val[2] = 1'b0;
    asg[4] = 1'b1; val[4] = 1'b0;
    run_scan(1'b0, 0, 0, 0, 0);
    asg[4] = 1'b0;
    run_scan(1'b0, 0, 0, 0, 0);
    check_store();

    // Load and start while busy are ignored
    sb_q.push_back(model_scan());
    sb_q[$].cyc = cyc + 5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    drive_load(0, 5, 6, 7);
    bus.start = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    wait_idle();
    tick();
    tick();
    chk("stray_start_ignored", 64'(bus.busy), 64'(0));
    check_store();

    // Reset in the second scan cycle aborts without a done pulse
    prev = done_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("async_reset_busy", 64'(bus.busy), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    repeat (6) tick();
    chk("no_done_after_abort", 64'(done_cnt), 64'(prev));
    check_reset_outs();
    check_store();

    // Same-cycle load and start; lowest-index unit tie-break in one bank
    asg = '0;
    val = '0;
    do_load(12, 20, 0, 0);
    do_load(13, -21, 0, 0);
    asg[8] = 1'b1; val[8] = 1'b0;
    run_scan(1'b1, 15, -8, 0, 0);
    check_store();

    // Randomized rounds
    for (int it = 0; it < 12; it++) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int v = 1; v <= 12; v++) begin
        asg[v] = 1'($urandom_range(0, 1));
        val[v] = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < n; k++) begin
        do_load(int'($urandom_range(0, NC - 1)), rand_lit(), rand_lit(), rand_lit());
      end
      run_scan(it[0], int'($urandom_range(0, NC - 1)), rand_lit(), rand_lit(), rand_lit());
      check_store();
    end

    repeat (3) tick();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
